// File: rtl/skid_buffer.sv
// Purpose  : two-entry ready/valid skid buffer; every output is driven by a flop.
// Latency  : a word accepted at edge N is presented on output_data from cycle N+1.
// Backpress: input_ready drops only when both entries are held; sustains 1 word/cycle.
//
// Ports:
//   clock        - single clock, all logic on its rising edge
//   clear_n      - synchronous active-low clear; empties the buffer and loads
//                  RESET_VALUE into both data registers
//   flush        - (only with SKID_BUFFER_FLUSH_EN) synchronous active-high
//                  discard; empties the buffer, leaves data registers as they are
//   input_valid  - upstream has a word on input_data
//   input_ready  - buffer accepts a word this cycle (registered)
//   input_data   - upstream word
//   output_valid - output_data holds a valid word (registered)
//   output_ready - downstream accepts output_data this cycle
//   output_data  - downstream word (registered)
//
// Optional feature macro: SKID_BUFFER_FLUSH_EN (adds the flush port).
// WORD_WIDTH defaults to 0 and must be overridden with a value of 1 or more.

module skid_buffer #(
   parameter int                    WORD_WIDTH  = 0,
   parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  clear_n,
`ifdef SKID_BUFFER_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic                  input_valid,
   output logic                  input_ready,
   input  logic [WORD_WIDTH-1:0] input_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic [WORD_WIDTH-1:0] output_data
);

   // EMPTY : nothing held
   // BUSY  : one word held in the output register
   // FULL  : output register and skid register both hold words
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [WORD_WIDTH-1:0]   skid_q;

   logic                    insert;
   logic                    remove;
   logic                    flush_req;

   // Datapath controls decoded from the state transition.
   logic                    load_output;   // write output register
   logic                    output_from_skid; // source of that write is the skid register
   logic                    load_skid;     // write skid register

`ifdef SKID_BUFFER_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // Handshakes use only registered ready/valid, so neither side sees a
   // combinational path from the other.
   assign insert = input_valid  & input_ready;
   assign remove = output_valid & output_ready;

   //-------------------------------------------------------------------------
   // State register
   //-------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   //-------------------------------------------------------------------------
   // Next-state and datapath control
   //-------------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      load_output      = 1'b0;
      output_from_skid = 1'b0;
      load_skid        = 1'b0;

      unique case (state_q)
         EMPTY: begin
            // load: first word goes straight to the output register
            if (insert) begin
               state_d     = BUSY;
               load_output = 1'b1;
            end
         end

         BUSY: begin
            if (insert && remove) begin
               // flow: replace the departing word in place
               load_output = 1'b1;
            end else if (insert) begin
               // fill: output is stalled, park the new word in the skid slot
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (remove) begin
               // unload
               state_d = EMPTY;
            end
         end

         FULL: begin
            // input_ready is 0 here, so only a remove can happen (drain)
            if (remove) begin
               state_d          = BUSY;
               load_output      = 1'b1;
               output_from_skid = 1'b1;
            end
         end

         default: begin
            state_d = EMPTY;
         end
      endcase

      // Flush discards both entries and suppresses every transfer this cycle.
      if (flush_req) begin
         state_d          = EMPTY;
         load_output      = 1'b0;
         output_from_skid = 1'b0;
         load_skid        = 1'b0;
      end
   end

   //-------------------------------------------------------------------------
   // Registered handshake outputs
   //-------------------------------------------------------------------------
   // Computed from the next state so they line up with state_q after the edge
   // while still being driven straight from flops.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         input_ready  <= 1'b1;
         output_valid <= 1'b0;
      end else begin
         input_ready  <= (state_d != FULL);
         output_valid <= (state_d != EMPTY);
      end
   end

   //-------------------------------------------------------------------------
   // Data registers
   //-------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         output_data <= RESET_VALUE;
         skid_q      <= RESET_VALUE;
      end else begin
         if (load_output) begin
            output_data <= output_from_skid ? skid_q : input_data;
         end
         if (load_skid) begin
            skid_q <= input_data;
         end
      end
   end

endmodule

// File: tb/tb_skid_buffer.sv
// Purpose  : directed and randomised checks of skid_buffer (WORD_WIDTH=8).
// Latency  : inputs change 1 time unit after a rising edge; outputs checked there.
// Backpress: the sender holds its word while input_ready is low.

module tb_skid_buffer;

   localparam int W = 8;

   logic         clock;
   logic         clear_n;
   logic         input_valid;
   logic         input_ready;
   logic [W-1:0] input_data;
   logic         output_valid;
   logic         output_ready;
   logic [W-1:0] output_data;
   logic         flush;

   int checks   = 0;
   int failures = 0;

   // Reference contents of the buffer, oldest first.
   logic [W-1:0] q[$];

   skid_buffer #(
      .WORD_WIDTH  (W),
      .RESET_VALUE (8'h00)
   ) dut (
      .clock        (clock),
      .clear_n      (clear_n),
`ifdef SKID_BUFFER_FLUSH_EN
      .flush        (flush),
`endif
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and update the reference queue with the transfers that
   // the edge performs.
   task automatic tick();
      logic         ins;
      logic         rem;
      logic         clr;
      logic         fl;
      logic [W-1:0] d;
      ins = input_valid & input_ready;
      rem = output_valid & output_ready;
      clr = !clear_n;
      fl  = flush;
      d   = input_data;
      @(posedge clock);
      #1;
      if (clr) begin
         q.delete();
      end else begin
`ifdef SKID_BUFFER_FLUSH_EN
         if (fl) begin
            q.delete();
         end else begin
`endif
            if (rem && q.size() > 0) void'(q.pop_front());
            if (ins) q.push_back(d);
`ifdef SKID_BUFFER_FLUSH_EN
         end
`endif
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_valid"}, {7'd0, output_valid}, {7'd0, (q.size() > 0)});
      check({tag, "_ready"}, {7'd0, input_ready},  {7'd0, (q.size() < 2)});
      if (q.size() > 0) check({tag, "_data"}, output_data, q[0]);
   endtask

   initial begin
      clear_n      = 1'b0;
      flush        = 1'b0;
      input_valid  = 1'b1;
      input_data   = 8'hA5;
      output_ready = 1'b0;
      #1;

      // ---- reset with a word presented: it must be dropped ----
      tick();
      tick();
      check("rst_ready", {7'd0, input_ready},  8'd1);
      check("rst_valid", {7'd0, output_valid}, 8'd0);
      check("rst_data",  output_data,          8'h00);
      clear_n     = 1'b1;
      input_valid = 1'b0;
      tick();
      check("rst_no_word", {7'd0, output_valid}, 8'd0);

      // ---- streaming: one word per cycle, one cycle latency ----
      output_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         input_valid = 1'b1;
         input_data  = i[7:0];
         check("stream_ready", {7'd0, input_ready}, 8'd1);
         tick();
         check("stream_valid", {7'd0, output_valid}, 8'd1);
         check("stream_data",  output_data,          i[7:0]);
      end
      input_valid = 1'b0;
      tick();
      check("stream_empty", {7'd0, output_valid}, 8'd0);

      // ---- backpressure: fill to FULL, then drain ----
      output_ready = 1'b0;
      input_valid  = 1'b1;
      input_data   = 8'h11;
      tick();
      check("bp_busy_ready", {7'd0, input_ready}, 8'd1);
      check("bp_busy_data",  output_data,         8'h11);
      input_data = 8'h22;
      tick();
      check("bp_full_ready", {7'd0, input_ready},  8'd0);
      check("bp_full_valid", {7'd0, output_valid}, 8'd1);
      check("bp_full_data",  output_data,          8'h11);
      input_data = 8'h33;
      tick();
      check("bp_hold_ready", {7'd0, input_ready}, 8'd0);
      check("bp_hold_data",  output_data,         8'h11);
      output_ready = 1'b1;
      tick();
      check("bp_drain_data",  output_data,         8'h22);
      check("bp_drain_ready", {7'd0, input_ready}, 8'd1);
      tick();
      check("bp_last_data",  output_data,          8'h33);
      check("bp_last_valid", {7'd0, output_valid}, 8'd1);
      input_valid = 1'b0;
      tick();
      check("bp_empty", {7'd0, output_valid}, 8'd0);

      // ---- clear while FULL discards both words ----
      output_ready = 1'b0;
      input_valid  = 1'b1;
      input_data   = 8'h44;
      tick();
      input_data = 8'h55;
      tick();
      check("mid_full_ready", {7'd0, input_ready}, 8'd0);
      input_valid = 1'b0;
      clear_n     = 1'b0;
      tick();
      clear_n = 1'b1;
      check("mid_rst_valid", {7'd0, output_valid}, 8'd0);
      check("mid_rst_ready", {7'd0, input_ready},  8'd1);
      check("mid_rst_data",  output_data,          8'h00);
      output_ready = 1'b1;
      tick();
      check("mid_no_word1", {7'd0, output_valid}, 8'd0);
      tick();
      check("mid_no_word2", {7'd0, output_valid}, 8'd0);

`ifdef SKID_BUFFER_FLUSH_EN
      // ---- flush while FULL ----
      output_ready = 1'b0;
      input_valid  = 1'b1;
      input_data   = 8'h77;
      tick();
      input_data = 8'h88;
      tick();
      check("fl_full_ready", {7'd0, input_ready}, 8'd0);
      output_ready = 1'b1;
      flush        = 1'b1;
      input_data   = 8'h99;
      tick();
      flush = 1'b0;
      check("fl_valid", {7'd0, output_valid}, 8'd0);
      check("fl_ready", {7'd0, input_ready},  8'd1);
      check("fl_data_kept", output_data,      8'h77);
      input_data = 8'h66;
      tick();
      check("fl_next_valid", {7'd0, output_valid}, 8'd1);
      check("fl_next_data",  output_data,          8'h66);
      input_valid = 1'b0;
      tick();
      check("fl_empty", {7'd0, output_valid}, 8'd0);
`endif

      // ---- random stalls against the reference queue ----
      q.delete();
      check_model("rnd_start");
      for (int c = 0; c < 4000; c++) begin
         // A stalled sender keeps its word; otherwise pick new traffic.
         if (!(input_valid && !input_ready)) begin
            input_valid = ($urandom_range(0, 3) != 0);
            input_data  = 8'($urandom_range(0, 255));
         end
         output_ready = ($urandom_range(0, 2) != 0);
         tick();
         check_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
